// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-state counter flagging when a memory access has waited too long
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between instruction fetch and data access
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  state_t        state, state_next;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          grant_i, grant_d;
  logic          expired;
  logic          finish;

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign finish     = (state == BUSY) && (mem_ready || expired);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_i || grant_d),
    .enable  ((state == BUSY) && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // Data normally wins; a starved fetch takes the slot once the limit is hit.
        if (i_req && (!d_req || starve_hit)) begin
          grant_i    = 1'b1;
          state_next = BUSY;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY:    if (mem_ready || expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= INSTR;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        owner      <= INSTR;
        mem_we     <= 1'b0;
        mem_addr   <= i_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end
      if (grant_d) begin
        owner     <= DATA;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (i_req && !starve_hit) starve_cnt <= starve_cnt + SW'(1);
      end
      // A timed-out access returns zero data and leaves the sticky error set.
      if (finish) begin
        if (!mem_ready) bus_err <= 1'b1;
        if (owner == INSTR) i_rdata <= mem_ready ? mem_rdata : '0;
        else                d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
      end
    end
  end

  assign mem_req = (state == BUSY);
  assign i_ready = (state == RESP) && (owner == INSTR);
  assign d_ready = (state == RESP) && (owner == DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32, DW = 32, TIMEOUT = 16, STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_req, mem_we, bus_err;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one access in flight, then one response cycle.
  bit          model_on = 1'b0;
  bit          m_busy, m_resp, m_own_d, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_miss, m_starve;

  always @(posedge clk) begin
    if (rst) begin
      model_on <= 1'b1;
      m_busy <= 0; m_resp <= 0; m_own_d <= 0; m_we <= 0; m_err <= 0;
      m_addr <= 0; m_wdata <= 0; m_irdata <= 0; m_drdata <= 0;
      m_miss <= 0; m_starve <= 0;
    end else if (m_resp) begin
      m_resp <= 0;
    end else if (m_busy) begin
      if (mem_ready || (m_miss + 1 == TIMEOUT)) begin
        m_busy <= 0;
        m_resp <= 1;
        if (!mem_ready) m_err <= 1;
        if (!m_own_d) m_irdata <= mem_ready ? mem_rdata : 32'h0;
        else          m_drdata <= (mem_ready && !m_we) ? mem_rdata : 32'h0;
      end else begin
        m_miss <= m_miss + 1;
      end
    end else if (i_req || d_req) begin
      m_busy <= 1;
      m_miss <= 0;
      if (i_req && (!d_req || m_starve >= STARVE_MAX)) begin
        m_own_d <= 0; m_we <= 0; m_addr <= i_addr; m_wdata <= 0; m_starve <= 0;
      end else begin
        m_own_d <= 1; m_we <= d_we; m_addr <= d_addr; m_wdata <= d_wdata;
        if (i_req) m_starve <= (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model mem_req",   32'(mem_req),   32'(m_busy));
      chk("model mem_we",    32'(mem_we),    32'(m_we));
      chk("model mem_addr",  mem_addr,       m_addr);
      chk("model mem_wdata", mem_wdata,      m_wdata);
      chk("model i_ready",   32'(i_ready),   32'(m_resp && !m_own_d));
      chk("model d_ready",   32'(d_ready),   32'(m_resp && m_own_d));
      chk("model i_rdata",   i_rdata,        m_irdata);
      chk("model d_rdata",   d_rdata,        m_drdata);
      chk("model bus_err",   32'(bus_err),   32'(m_err));
    end
  end

  logic [31:0] seq[$];
  int          irdy_at[$];
  logic [31:0] exp_seq[10];
  int          nreq, nrdy;
  bit          slow, i_done, d_done;

  initial begin
    rst = 1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset ready", 32'({i_ready, d_ready}), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset rdata", i_rdata | d_rdata, 32'd0);

    // Single fetch
    step(); i_req = 1; i_addr = 32'h0000_0040;
    step(); mem_ready = 1; mem_rdata = 32'h2008_0005;
    @(negedge clk);
    chk("fetch mem_req", 32'(mem_req), 32'd1);
    chk("fetch mem_addr", mem_addr, 32'h40);
    step(); mem_ready = 0;
    @(negedge clk);
    chk("fetch i_ready", 32'(i_ready), 32'd1);
    chk("fetch i_rdata", i_rdata, 32'h2008_0005);
    step(); i_req = 0;
    @(negedge clk);
    chk("fetch idle", 32'({i_ready, mem_req}), 32'd0);

    // Store with three wait states
    step(); d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      step(); mem_ready = (k == 3); mem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("store mem_req", 32'(mem_req), 32'd1);
      chk("store mem_we", 32'(mem_we), 32'd1);
      chk("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("store early ready", 32'(d_ready), 32'd0);
    end
    step(); mem_ready = 0;
    @(negedge clk);
    chk("store d_ready", 32'(d_ready), 32'd1);
    chk("store d_rdata", d_rdata, 32'd0);
    step(); d_req = 0; d_we = 0;

    // Contention: both held, memory answers at once
    exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100,
                32'h200, 32'h200, 32'h200, 32'h200, 32'h100};
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 0) begin
        i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        mem_ready = 1; mem_rdata = 32'hA5A5_A5A5;
      end
      @(negedge clk);
      if (mem_req) seq.push_back(mem_addr);
      if (i_ready) irdy_at.push_back(k);
    end
    step(); i_req = 0; d_req = 0; mem_ready = 0;
    chk("starve grant count", 32'(seq.size()), 32'd10);
    for (int k = 0; k < 10 && k < seq.size(); k++) chk("starve grant order", seq[k], exp_seq[k]);
    chk("starve i_ready count", 32'(irdy_at.size()), 32'd2);
    if (irdy_at.size() == 2) chk("starve i_ready spacing", 32'(irdy_at[1] - irdy_at[0]), 32'd15);
    chk("starve d_rdata", d_rdata, 32'hA5A5_A5A5);

    // Timeout on a load
    step(); d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int k = 1; k <= 17; k++) begin
      step();
      @(negedge clk);
      chk("timeout d_ready", 32'(d_ready), 32'(k == 17));
      chk("timeout bus_err", 32'(bus_err), 32'(k == 17));
      if (k == 17) chk("timeout d_rdata", d_rdata, 32'd0);
    end
    step(); d_req = 0;
    step(); i_req = 1; i_addr = 32'h44;
    step(); mem_ready = 1; mem_rdata = 32'h1111_2222;
    step(); mem_ready = 0;
    @(negedge clk);
    chk("post-timeout i_ready", 32'(i_ready), 32'd1);
    chk("bus_err sticky", 32'(bus_err), 32'd1);
    step(); i_req = 0;

    // Reset during the second BUSY cycle
    step(); d_req = 1; d_addr = 32'h400;
    step();
    step(); rst = 1;
    @(negedge clk);
    chk("rst-busy mem_req before", 32'(mem_req), 32'd1);
    step(); rst = 0; d_req = 0;
    @(negedge clk);
    chk("rst-busy mem_req", 32'(mem_req), 32'd0);
    chk("rst-busy no ready", 32'({i_ready, d_ready}), 32'd0);
    chk("rst-busy bus_err", 32'(bus_err), 32'd0);
    step();
    @(negedge clk);
    chk("rst-busy quiet", 32'({mem_req, d_ready}), 32'd0);
    step(); i_req = 1; i_addr = 32'h48;
    step(); mem_ready = 1; mem_rdata = 32'h3333_4444;
    step(); mem_ready = 0;
    @(negedge clk);
    chk("rst-busy refetch i_ready", 32'(i_ready), 32'd1);
    chk("rst-busy refetch i_rdata", i_rdata, 32'h3333_4444);
    step(); i_req = 0;

    // Request still high during the response cycle must not be granted again
    nreq = 0; nrdy = 0;
    step(); d_req = 1; d_addr = 32'h500; mem_ready = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) d_req = 0;
      @(negedge clk);
      if (mem_req) nreq++;
      if (d_ready) nrdy++;
    end
    chk("regrant mem_req cycles", 32'(nreq), 32'd1);
    chk("regrant d_ready pulses", 32'(nrdy), 32'd1);
    mem_ready = 0;

    // Randomized traffic against the model
    slow = 0; i_done = 0; d_done = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (n % 250 == 0) slow = ($urandom % 4 == 0);
      rst       = ($urandom % 400 == 0);
      mem_ready = slow ? ($urandom % 30 == 0) : ($urandom % 3 != 0);
      mem_rdata = $urandom;
      if (!i_req || i_done) begin
        i_req = $urandom % 2; i_addr = $urandom;
      end
      if (!d_req || d_done) begin
        d_req = $urandom % 2; d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end
      @(negedge clk);
      i_done = i_ready;
      d_done = d_ready;
    end
    step(); rst = 0; i_req = 0; d_req = 0; mem_ready = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
